// File: rtl/bus_seq_pkg.sv
// Shared definitions for the bus sequencer: opcodes, bus source indices,
// FSM state encoding and instruction classes.
package bus_seq_pkg;

  localparam int NUM_REGS_DEF = 16;
  localparam int DRV_W_DEF    = 24;
  localparam int OP_W_DEF     = 5;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_SHR  = 5'd4;
  localparam logic [4:0] OP_SHL  = 5'd5;
  localparam logic [4:0] OP_ROR  = 5'd6;
  localparam logic [4:0] OP_ROL  = 5'd7;
  localparam logic [4:0] OP_NEG  = 5'd8;
  localparam logic [4:0] OP_ADDI = 5'd9;
  localparam logic [4:0] OP_MUL  = 5'd10;
  localparam logic [4:0] OP_DIV  = 5'd11;
  localparam logic [4:0] OP_MFHI = 5'd12;
  localparam logic [4:0] OP_MFLO = 5'd13;
  localparam logic [4:0] OP_IN   = 5'd14;
  localparam logic [4:0] OP_NOP  = 5'd15;
  localparam logic [4:0] OP_HALT = 5'd16;

  localparam int DRV_R0     = 0;
  localparam int DRV_HI     = 16;
  localparam int DRV_LO     = 17;
  localparam int DRV_ZHI    = 18;
  localparam int DRV_ZLO    = 19;
  localparam int DRV_PC     = 20;
  localparam int DRV_MDR    = 21;
  localparam int DRV_INPORT = 22;
  localparam int DRV_C      = 23;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_F0     = 4'd1,
    ST_F1     = 4'd2,
    ST_F2     = 4'd3,
    ST_EX_A   = 4'd4,
    ST_EX_B   = 4'd5,
    ST_EX_C   = 4'd6,
    ST_EX_D   = 4'd7,
    ST_HALTED = 4'd8,
    ST_TRAP   = 4'd9
  } state_e;

  typedef enum logic [3:0] {
    CLS_ALU     = 4'd0,
    CLS_ADDI    = 4'd1,
    CLS_MULDIV  = 4'd2,
    CLS_MFHI    = 4'd3,
    CLS_MFLO    = 4'd4,
    CLS_IN      = 4'd5,
    CLS_NOP     = 4'd6,
    CLS_HALT    = 4'd7,
    CLS_ILLEGAL = 4'd8
  } ins_class_e;

endpackage

// File: rtl/bus_sequencer_decode.sv
// Opcode decoder: instruction class plus index of the last execute state
// (0=EX_A .. 3=EX_D). Illegal opcodes map to a trap class under ILLEGAL_OP_TRAP_EN.
import bus_seq_pkg::*;

module bus_seq_decode (
  input  logic [4:0]  op_i,
  output ins_class_e  cls_o,
  output logic [1:0]  ex_last_o
);

  always_comb begin
    cls_o     = CLS_NOP;
    ex_last_o = 2'd0;
    if (op_i <= OP_NEG) begin
      cls_o     = CLS_ALU;
      ex_last_o = 2'd2;
    end else begin
      case (op_i)
        OP_ADDI: begin
          cls_o     = CLS_ADDI;
          ex_last_o = 2'd2;
        end
        OP_MUL, OP_DIV: begin
          cls_o     = CLS_MULDIV;
          ex_last_o = 2'd3;
        end
        OP_MFHI: cls_o = CLS_MFHI;
        OP_MFLO: cls_o = CLS_MFLO;
        OP_IN:   cls_o = CLS_IN;
        OP_NOP:  cls_o = CLS_NOP;
        OP_HALT: cls_o = CLS_HALT;
`ifdef ILLEGAL_OP_TRAP_EN
        default: cls_o = CLS_ILLEGAL;
`else
        default: cls_o = CLS_NOP;
`endif
      endcase
    end
  end

endmodule

// File: rtl/bus_sequencer.sv
// Hardwired fetch/execute sequencer driving the shared CPU bus (Moore outputs).
// Optional ILLEGAL_OP_TRAP_EN: opcodes 17-31 enter a sticky TRAP state instead of acting as NOP.
import bus_seq_pkg::*;

module bus_sequencer #(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int DRV_W    = DRV_W_DEF,
  parameter int OP_W     = OP_W_DEF
) (
  input  logic                clock_i,
  input  logic                clear_i,
  input  logic                run_i,
  input  logic [31:0]         ir_i,
  input  logic                mem_ready_i,
  output logic [DRV_W-1:0]    drv_sel_o,
  output logic [NUM_REGS-1:0] reg_in_o,
  output logic                ld_pc_o,
  output logic                ld_ir_o,
  output logic                ld_mar_o,
  output logic                ld_mdr_o,
  output logic                ld_y_o,
  output logic                ld_z_o,
  output logic                ld_hi_o,
  output logic                ld_lo_o,
  output logic                inc_pc_o,
  output logic                mem_read_o,
  output logic [OP_W-1:0]     alu_op_o,
  output logic                busy_o,
  output logic                halted_o,
  output logic                trap_o
);

  state_e     state_q, state_d;
  ins_class_e cls;
  logic [1:0] ex_last;
  logic       ex_done;

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic       ir_unused;

  assign op        = ir_i[31:27];
  assign ra        = ir_i[26:23];
  assign rb        = ir_i[22:19];
  assign rc        = ir_i[18:15];
  assign ir_unused = ^ir_i[14:0];

  bus_seq_decode u_decode (
    .op_i      (op),
    .cls_o     (cls),
    .ex_last_o (ex_last)
  );

  always_ff @(posedge clock_i or posedge clear_i) begin
    if (clear_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    ex_done    = 1'b0;
    drv_sel_o  = '0;
    reg_in_o   = '0;
    ld_pc_o    = 1'b0;
    ld_ir_o    = 1'b0;
    ld_mar_o   = 1'b0;
    ld_mdr_o   = 1'b0;
    ld_y_o     = 1'b0;
    ld_z_o     = 1'b0;
    ld_hi_o    = 1'b0;
    ld_lo_o    = 1'b0;
    inc_pc_o   = 1'b0;
    mem_read_o = 1'b0;
    alu_op_o   = '0;
    busy_o     = 1'b0;
    halted_o   = 1'b0;
    trap_o     = 1'b0;

    case (state_q)
      ST_IDLE: if (run_i) state_d = ST_F0;
      ST_F0: begin
        busy_o            = 1'b1;
        drv_sel_o[DRV_PC] = 1'b1;
        ld_mar_o          = 1'b1;
        inc_pc_o          = 1'b1;
        ld_z_o            = 1'b1;
        state_d           = ST_F1;
      end
      // PC/MDR loads repeat while waiting; the values do not change.
      ST_F1: begin
        busy_o             = 1'b1;
        drv_sel_o[DRV_ZLO] = 1'b1;
        ld_pc_o            = 1'b1;
        mem_read_o         = 1'b1;
        ld_mdr_o           = 1'b1;
        if (mem_ready_i) state_d = ST_F2;
      end
      ST_F2: begin
        busy_o             = 1'b1;
        drv_sel_o[DRV_MDR] = 1'b1;
        ld_ir_o            = 1'b1;
        state_d            = ST_EX_A;
      end
      ST_EX_A: begin
        busy_o = 1'b1;
        case (cls)
          CLS_ALU, CLS_ADDI, CLS_MULDIV: begin
            drv_sel_o = DRV_W'(1) << (DRV_R0 + int'(rb));
            ld_y_o    = 1'b1;
          end
          CLS_MFHI: begin
            drv_sel_o[DRV_HI] = 1'b1;
            reg_in_o          = NUM_REGS'(1) << ra;
          end
          CLS_MFLO: begin
            drv_sel_o[DRV_LO] = 1'b1;
            reg_in_o          = NUM_REGS'(1) << ra;
          end
          CLS_IN: begin
            drv_sel_o[DRV_INPORT] = 1'b1;
            reg_in_o              = NUM_REGS'(1) << ra;
          end
          default: ;
        endcase
        if (cls == CLS_HALT)              state_d = ST_HALTED;
`ifdef ILLEGAL_OP_TRAP_EN
        else if (cls == CLS_ILLEGAL)      state_d = ST_TRAP;
`endif
        else if (ex_last == 2'd0)         ex_done = 1'b1;
        else                              state_d = ST_EX_B;
      end
      ST_EX_B: begin
        busy_o = 1'b1;
        ld_z_o = 1'b1;
        if (cls == CLS_ADDI) begin
          drv_sel_o[DRV_C] = 1'b1;
        end else begin
          drv_sel_o = DRV_W'(1) << (DRV_R0 + int'(rc));
          alu_op_o  = OP_W'(op);
        end
        if (ex_last == 2'd1) ex_done = 1'b1;
        else                 state_d = ST_EX_C;
      end
      ST_EX_C: begin
        busy_o             = 1'b1;
        drv_sel_o[DRV_ZLO] = 1'b1;
        if (cls == CLS_MULDIV) ld_lo_o  = 1'b1;
        else                   reg_in_o = NUM_REGS'(1) << ra;
        if (ex_last == 2'd2) ex_done = 1'b1;
        else                 state_d = ST_EX_D;
      end
      ST_EX_D: begin
        busy_o             = 1'b1;
        drv_sel_o[DRV_ZHI] = 1'b1;
        ld_hi_o            = 1'b1;
        ex_done            = 1'b1;
      end
      ST_HALTED: halted_o = 1'b1;
      ST_TRAP: begin
`ifdef ILLEGAL_OP_TRAP_EN
        trap_o = 1'b1;
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    if (ex_done) state_d = run_i ? ST_F0 : ST_IDLE;
  end

endmodule
